// File: rtl/interface_pkg.sv
// Shared types and constants for the instruction-cache core and its line store.
package interface_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } icache_state_e;

    localparam int          LINE_WORDS         = 4;
    localparam int          WORD_OFF_BITS      = 2;
    localparam int          LINE_OFF_BITS      = 4;
    localparam logic [31:0] LINE_BOUNDARY_MASK = 32'hFFFF_FFF0;

    // Refill beats walk the line starting at the critical word and wrap at the line end.
    function automatic logic [WORD_OFF_BITS-1:0] wrap_word(
        input logic [WORD_OFF_BITS-1:0] crit,
        input logic [WORD_OFF_BITS-1:0] beat
    );
        return crit + beat;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: combinational lookup,
// one word write port, line tag/valid set, and whole-cache flush.
module icache_line_store
    import interface_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [INDEX_BITS-1:0]    rd_idx,
    input  logic [TAG_BITS-1:0]      rd_tag,
    input  logic [WORD_OFF_BITS-1:0] rd_word,
    output logic                     rd_hit,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [INDEX_BITS-1:0]    wr_idx,
    input  logic [WORD_OFF_BITS-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     set_en,
    input  logic [TAG_BITS-1:0]      set_tag
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [TAG_BITS-1:0] tag_d  [LINES];
    logic [31:0]         data_q [LINES][LINE_WORDS];
    logic [31:0]         data_d [LINES][LINE_WORDS];

    // Lookup port: hit needs a valid line with a matching tag.
    always_comb begin
        rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_data = data_q[rd_idx][rd_word];
    end

    // Flush clears everything first; a line set in the same cycle still lands
    // (the core never requests a set while flushing).
    always_comb begin
        valid_d = flush ? '0 : valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_word] = wr_data;
        end
        if (set_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = set_tag;
        end
    end

    // Valid bits need reset; they alone decide whether tag/data are meaningful.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/icache_core.sv
// Direct-mapped instruction cache core: lookup, critical-word-first line refill,
// early restart, and busy back-pressure to the AHB side.
//
//  state  | meaning
//  IDLE   | lookups accepted; a miss latches the line and starts a refill
//  REFILL | memory beats in flight; busy and mem_req high
//  DONE   | one quiet cycle for the upstream re-issue; no lookup
module icache_core
    import interface_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int IDX_LSB  = LINE_OFF_BITS;
    localparam int TAG_LSB  = LINE_OFF_BITS + INDEX_BITS;

    icache_state_e              state_q, state_d;
    logic [31:0]                line_base_q, line_base_d;
    logic [WORD_OFF_BITS-1:0]   crit_q, crit_d;
    logic [WORD_OFF_BITS-1:0]   beat_q, beat_d;
    logic                       flush_pend_q, flush_pend_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       rdata_valid_q, rdata_valid_d;

    logic                       lk_hit_raw, lk_hit;
    logic [31:0]                lk_data;
    logic [WORD_OFF_BITS-1:0]   cur_word;
    logic                       wr_en, set_en;
    logic                       last_ack;

    assign cur_word = wrap_word(crit_q, beat_q);
    assign lk_hit   = lk_hit_raw && !flush;
    assign last_ack = (state_q == REFILL) && mem_ack && (beat_q == 2'd3);

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .rd_idx  (req_addr[TAG_LSB-1:IDX_LSB]),
        .rd_tag  (req_addr[31:TAG_LSB]),
        .rd_word (req_addr[IDX_LSB-1:2]),
        .rd_hit  (lk_hit_raw),
        .rd_data (lk_data),
        .wr_en   (wr_en),
        .wr_idx  (line_base_q[TAG_LSB-1:IDX_LSB]),
        .wr_word (cur_word),
        .wr_data (mem_rdata),
        .set_en  (set_en),
        .set_tag (line_base_q[31:TAG_LSB])
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: miss starts a refill, the fourth beat ends it, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && !lk_hit) state_d = REFILL;
            REFILL:  if (last_ack)             state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake is decoded from state so reset drops it immediately.
    always_comb begin
        busy     = (state_q == REFILL);
        mem_req  = (state_q == REFILL);
        mem_addr = '0;
        if (state_q == REFILL) begin
            mem_addr = line_base_q | {28'd0, cur_word, 2'b00};
        end
    end

    // Datapath: hit return, miss capture, beat writes, early restart, flush tracking.
    always_comb begin
        line_base_d   = line_base_q;
        crit_d        = crit_q;
        beat_d        = beat_q;
        flush_pend_d  = flush_pend_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        wr_en         = 1'b0;
        set_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && lk_hit) begin
                    rdata_d       = lk_data;
                    rdata_valid_d = 1'b1;
                end else if (req_valid) begin
                    line_base_d = req_addr & LINE_BOUNDARY_MASK;
                    crit_d      = req_addr[IDX_LSB-1:2];
                    beat_d      = '0;
                end
            end
            REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd0) begin
                        rdata_d       = mem_rdata;
                        rdata_valid_d = 1'b1;
                    end
                    if (beat_q == 2'd3) begin
                        set_en       = !(flush_pend_q || flush);
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_base_q   <= '0;
            crit_q        <= '0;
            beat_q        <= '0;
            flush_pend_q  <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            line_base_q   <= line_base_d;
            crit_q        <= crit_d;
            beat_q        <= beat_d;
            flush_pend_q  <= flush_pend_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_icache_core.sv
// Directed bench for icache_core: table of lookups plus hand-written refill,
// flush and reset sequences against a bench-side memory pattern.
module tb_icache_core;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic        fl;
        logic        hit;
    } vec_t;

    vec_t tab [18];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_rdata = memf(mem_addr);

    icache_core #(.INDEX_BITS(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .flush       (flush),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-cycle hit; entered and left at posedge+1.
    task automatic lookup(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hit_valid", {31'd0, rdata_valid}, 32'd1);
        chk("hit_data", rdata, memf({addr[31:2], 2'b00}));
        chk("hit_busy", {31'd0, busy}, 32'd0);
        chk("hit_memreq", {31'd0, mem_req}, 32'd0);
    endtask

    // Miss followed by a full refill; bit i of ackp/flp drives mem_ack/flush in refill cycle i.
    task automatic refill(input logic [31:0] addr, input logic fl0,
                          input logic [15:0] ackp, input logic [15:0] flp);
        logic [1:0]  crit;
        logic [1:0]  w;
        logic [31:0] exp_a;
        logic [31:0] first_a;
        int          beats;
        int          cyc;
        crit    = addr[3:2];
        first_a = {addr[31:4], crit, 2'b00};
        beats   = 0;
        cyc     = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        flush     = fl0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("miss_busy", {31'd0, busy}, 32'd1);
        chk("miss_memreq", {31'd0, mem_req}, 32'd1);
        chk("miss_no_rvalid", {31'd0, rdata_valid}, 32'd0);
        while (beats < 4 && cyc < 40) begin
            w     = crit + beats[1:0];
            exp_a = {addr[31:4], w, 2'b00};
            chk("refill_addr", mem_addr, exp_a);
            chk("refill_busy", {31'd0, busy}, 32'd1);
            mem_ack = (cyc < 16) ? ackp[cyc] : 1'b1;
            flush   = (cyc < 16) ? flp[cyc] : 1'b0;
            @(posedge clk); #1;
            if (mem_ack) beats++;
            if (mem_ack && beats == 1) begin
                chk("early_rvalid", {31'd0, rdata_valid}, 32'd1);
                chk("early_rdata", rdata, memf(first_a));
            end else begin
                chk("refill_rvalid", {31'd0, rdata_valid}, 32'd0);
            end
            mem_ack = 1'b0;
            flush   = 1'b0;
            cyc++;
        end
        chk("refill_beats", beats, 32'd4);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_memreq", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tab[i].hit) lookup(tab[i].addr);
            else            refill(tab[i].addr, tab[i].fl, 16'hFFFF, 16'h0000);
        end
    endtask

    initial begin
        tab[0]  = '{32'h0000_0044, 1'b0, 1'b1};
        tab[1]  = '{32'h0000_0040, 1'b0, 1'b1};
        tab[2]  = '{32'h0000_004C, 1'b0, 1'b1};
        tab[3]  = '{32'h0000_0048, 1'b0, 1'b1};
        tab[4]  = '{32'h0000_0148, 1'b0, 1'b0};
        tab[5]  = '{32'h0000_014C, 1'b0, 1'b1};
        tab[6]  = '{32'h0000_0140, 1'b0, 1'b1};
        tab[7]  = '{32'h0000_0048, 1'b0, 1'b0};
        tab[8]  = '{32'h0000_0144, 1'b0, 1'b0};
        tab[9]  = '{32'h0000_0140, 1'b0, 1'b1};
        tab[10] = '{32'h0000_0148, 1'b1, 1'b0};
        tab[11] = '{32'h0000_014C, 1'b0, 1'b1};
        tab[12] = '{32'h0000_00C0, 1'b0, 1'b1};
        tab[13] = '{32'h0000_00C4, 1'b0, 1'b1};
        tab[14] = '{32'h0000_00CC, 1'b0, 1'b1};
        tab[15] = '{32'h0000_00C8, 1'b0, 1'b1};
        tab[16] = '{32'h0000_0044, 1'b0, 1'b0};
        tab[17] = '{32'h0000_0048, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);

        // Cold miss: 0x48, 0x4C, 0x40, 0x44 with ack every cycle.
        refill(32'h0000_0048, 1'b0, 16'hFFFF, 16'h0000);
        run_vecs(0, 11);

        // Gapped acks 1,0,0,1,0,1,1.
        refill(32'h0000_00C8, 1'b0, 16'h0069, 16'h0000);
        run_vecs(12, 17);

        // Acks with no refill outstanding change nothing.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("idle_ack_memaddr", mem_addr, 32'd0);
        lookup(32'h0000_0044);

        // Flush during the beat-2 wait; line stays invalid and 0x44 is gone too.
        refill(32'h0000_0080, 1'b0, 16'h001B, 16'h0004);
        refill(32'h0000_0080, 1'b0, 16'hFFFF, 16'h0000);
        refill(32'h0000_0044, 1'b0, 16'hFFFF, 16'h0000);
        lookup(32'h0000_0080);

        // Reset after the second beat of a refill at 0xA34.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0A34;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rr_addr0", mem_addr, 32'h0000_0A34);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("rr_addr1", mem_addr, 32'h0000_0A38);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rr_addr2", mem_addr, 32'h0000_0A3C);
        rstn = 1'b0;
        #1;
        chk("rr_memreq", {31'd0, mem_req}, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_memaddr", mem_addr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        refill(32'h0000_0A34, 1'b0, 16'hFFFF, 16'h0000);
        refill(32'h0000_0048, 1'b0, 16'hFFFF, 16'h0000);
        lookup(32'h0000_0A30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
